core_write_lsu: RTL



---
 rtl/core_pkg.sv | 50 +++++
 rtl/core_load_extract.sv | 63 ++++++
 rtl/core_write_lsu.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared result-source codes, load funct3 encodings and the
//               write/LSU FSM state type.
// Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam logic [1:0] RESULT_SRC_ALU    = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEMORY = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC_P4  = 2'b10;

    typedef enum logic [2:0] {
        LOAD_LB  = 3'b000,
        LOAD_LH  = 3'b001,
        LOAD_LW  = 3'b010,
        LOAD_LD  = 3'b011,
        LOAD_LBU = 3'b100,
        LOAD_LHU = 3'b101,
        LOAD_LWU = 3'b110
    } load_funct3_e;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_RD0  = 2'd1;
    localparam lsu_state_t ST_RD1  = 2'd2;
    localparam lsu_state_t ST_RESP = 2'd3;

    // Access size in bytes; the low two funct3 bits encode log2(size).
    function automatic logic [3:0] load_size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic load_legal(input logic [2:0] funct3, input logic is64);
        case (funct3)
            LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU: return 1'b1;
            LOAD_LD, LOAD_LWU:                             return is64;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : core_load_extract
// Description : Combinational merge of two bus words, byte alignment and
//               sign/zero extension of the loaded value.
// Revision    : 1.0  initial release
// ============================================================================
module core_load_extract
    import core_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int OFFS_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]   i_hi,
    input  logic [XLEN-1:0]   i_lo,
    input  logic [OFFS_W-1:0] i_offset,
    input  logic [2:0]        i_funct3,
    output logic [XLEN-1:0]   o_data,
    output logic              o_illegal
);

    localparam logic c_is64 = (XLEN == 64);

    logic [2*XLEN-1:0] w_merged;
    logic [XLEN-1:0]   w_raw;

    assign w_merged = {i_hi, i_lo} >> {i_offset, 3'b000};
    assign w_raw    = w_merged[XLEN-1:0];

    // Keep the low 'bits' bits of v and extend them back to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input int bits,
                                               input logic sgn);
        logic        [XLEN-1:0] sh;
        logic signed [XLEN-1:0] s;
        sh = v << (XLEN - bits);
        s  = $signed(sh) >>> (XLEN - bits);
        return sgn ? s : (sh >> (XLEN - bits));
    endfunction

    always_comb begin
        o_data    = '0;
        o_illegal = 1'b0;
        case (i_funct3)
            LOAD_LB:  o_data = extend(w_raw, 8, 1'b1);
            LOAD_LH:  o_data = extend(w_raw, 16, 1'b1);
            LOAD_LW:  o_data = extend(w_raw, 32, 1'b1);
            LOAD_LBU: o_data = extend(w_raw, 8, 1'b0);
            LOAD_LHU: o_data = extend(w_raw, 16, 1'b0);
            LOAD_LD: begin
                if (c_is64) o_data = w_raw;
                else        o_illegal = 1'b1;
            end
            LOAD_LWU: begin
                if (c_is64) o_data = extend(w_raw, 32, 1'b0);
                else        o_illegal = 1'b1;
            end
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/core_write_lsu.sv
`default_nettype none
// ============================================================================
// Module      : core_write_lsu
// Description : Registered write-back stage with its own aligned load port;
//               splits word-crossing loads into two bus reads.
// Revision    : 1.0  initial release
// ============================================================================
module core_write_lsu
    import core_pkg::*;
#(
    parameter  int XLEN        = 32,
    parameter  bit MISALIGN_EN = 1'b1,
    localparam int OFFS_W      = $clog2(XLEN / 8)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [XLEN-1:0]          i_alu_result,
    input  logic [XLEN-3:0]          i_pc_p4,
    input  logic [2:0]               i_funct3,
    input  logic [1:0]               i_res_src,
    input  logic [4:0]               i_rd,
    output logic                     o_bus_req,
    output logic [XLEN-OFFS_W-1:0]   o_bus_addr,
    input  logic                     i_bus_ack,
    input  logic [XLEN-1:0]          i_bus_rdata,
    input  logic                     i_bus_err,
    output logic                     o_wb_valid,
    output logic [4:0]               o_wb_rd,
    output logic [XLEN-1:0]          o_wb_data,
    output logic                     o_load_fault
);

    localparam int   c_word_w = XLEN - OFFS_W;
    localparam logic c_is64   = (XLEN == 64);
    localparam int   c_bytes  = XLEN / 8;

    lsu_state_t            r_state;
    logic [4:0]            r_rd;
    logic [2:0]            r_funct3;
    logic [OFFS_W-1:0]     r_offset;
    logic [c_word_w-1:0]   r_word;
    logic                  r_cross;
    logic [XLEN-1:0]       r_lo;
    logic [XLEN-1:0]       r_wb_data;
    logic                  r_fault;

    logic                  w_accept;
    logic                  w_is_load;
    logic [4:0]            w_end;
    logic                  w_cross;
    logic                  w_fault_at_accept;
    logic [XLEN-1:0]       w_nonload_data;
    logic [XLEN-1:0]       w_ext_lo;
    logic [XLEN-1:0]       w_ext_data;
    logic                  w_ext_illegal;

    // RESP doubles as an idle state so a new request can overlap the write-back pulse.
    assign o_ready   = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign w_accept  = i_valid && o_ready;
    assign w_is_load = (i_res_src == RESULT_SRC_MEMORY);

    assign w_end   = 5'(i_alu_result[OFFS_W-1:0]) + 5'(load_size_bytes(i_funct3));
    assign w_cross = (w_end > 5'(c_bytes));
    assign w_fault_at_accept = !load_legal(i_funct3, c_is64) || (w_cross && !MISALIGN_EN);

    always_comb begin
        w_nonload_data = '0;
        case (i_res_src)
            RESULT_SRC_ALU:   w_nonload_data = i_alu_result;
            RESULT_SRC_PC_P4: w_nonload_data = {i_pc_p4, 2'b00};
            default:          w_nonload_data = '0;
        endcase
    end

    // In RD1 the live bus word is the upper half; the first word was parked in r_lo.
    assign w_ext_lo = (r_state == ST_RD1) ? r_lo : i_bus_rdata;

    core_load_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .i_hi      (i_bus_rdata),
        .i_lo      (w_ext_lo),
        .i_offset  (r_offset),
        .i_funct3  (r_funct3),
        .o_data    (w_ext_data),
        .o_illegal (w_ext_illegal)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_offset  <= '0;
            r_word    <= '0;
            r_cross   <= 1'b0;
            r_lo      <= '0;
            r_wb_data <= '0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_accept) begin
                        r_rd     <= i_rd;
                        r_funct3 <= i_funct3;
                        r_offset <= i_alu_result[OFFS_W-1:0];
                        r_word   <= i_alu_result[XLEN-1:OFFS_W];
                        r_cross  <= w_cross;
                        if (!w_is_load) begin
                            r_wb_data <= w_nonload_data;
                            r_fault   <= 1'b0;
                            r_state   <= ST_RESP;
                        end else if (w_fault_at_accept) begin
                            r_wb_data <= '0;
                            r_fault   <= 1'b1;
                            r_state   <= ST_RESP;
                        end else begin
                            r_state <= ST_RD0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD0: begin
                    if (i_bus_ack) begin
                        r_lo <= i_bus_rdata;
                        if (i_bus_err) begin
                            r_wb_data <= '0;
                            r_fault   <= 1'b1;
                            r_state   <= ST_RESP;
                        end else if (r_cross) begin
                            r_state <= ST_RD1;
                        end else begin
                            r_wb_data <= w_ext_data;
                            r_fault   <= w_ext_illegal;
                            r_state   <= ST_RESP;
                        end
                    end
                end
                ST_RD1: begin
                    if (i_bus_ack) begin
                        r_wb_data <= i_bus_err ? '0 : w_ext_data;
                        r_fault   <= i_bus_err | w_ext_illegal;
                        r_state   <= ST_RESP;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_bus_req    = (r_state == ST_RD0) || (r_state == ST_RD1);
    assign o_bus_addr   = (r_state == ST_RD1) ? (r_word + c_word_w'(1)) : r_word;
    assign o_wb_valid   = (r_state == ST_RESP);
    assign o_wb_rd      = r_rd;
    assign o_wb_data    = r_wb_data;
    assign o_load_fault = r_fault;

endmodule
`default_nettype wire
